soc_fifo_rd_stream: RTL and testbench



---
 rtl/soc_fifo_pkg.sv | 27 ++
 rtl/soc_fifo_rd_stream_buf.sv | 72 +++++++
 rtl/soc_fifo_rd_stream.sv | 96 +++++++++
 tb/tb_soc_fifo_rd_stream.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_fifo_pkg.sv
// Shared constants and helpers for the dual-clock FIFO read-side stream.
// Also provides SOC_FIFO_CHECK_DIV, an elaboration-time guard that DW divides evenly by OW.
`ifndef SOC_FIFO_PKG_SV
`define SOC_FIFO_PKG_SV

`define SOC_FIFO_CHECK_DIV(dw, ow) \
  if ((((dw) % (ow)) != 0) || ((ow) > (dw))) begin : g_bad_ratio \
    $error("soc_fifo: DW must be a non-zero integer multiple of OW"); \
  end

package soc_fifo_pkg;

  localparam int unsigned SOC_FIFO_DW = 32;
  localparam int unsigned SOC_FIFO_OW = 8;

  function automatic int unsigned soc_fifo_ratio(input int unsigned dw, input int unsigned ow);
    return dw / ow;
  endfunction

  // A one-beat word still needs a 1-bit index so the counter stays a legal vector.
  function automatic int unsigned soc_fifo_idx_w(input int unsigned ratio);
    return (ratio > 32'd1) ? $clog2(ratio) : 32'd1;
  endfunction

endpackage

`endif

// File: rtl/soc_fifo_rd_stream_buf.sv
// Two-entry prefetch word buffer for the FIFO read stream.
// Capture writes at wr_ptr, release retires the word at rd_ptr; flush empties it.
module soc_fifo_rd_stream_buf
  import soc_fifo_pkg::*;
#(
  parameter int unsigned DW = SOC_FIFO_DW
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic          flush_i,
  input  logic          capture_i,
  input  logic          release_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic [1:0]    cnt_o
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_ptr_q;
  logic          wr_ptr_d;
  logic          rd_ptr_q;
  logic          rd_ptr_d;
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_d;

  // Next-state: flush drops everything and takes priority over capture/release.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (capture_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (release_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, capture_i} - {1'b0, release_i};
    end
  end

  // Buffer state registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      mem_q[0] <= {DW{1'b0}};
      mem_q[1] <= {DW{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/soc_fifo_rd_stream.sv
// FIFO read-side consumer: prefetches words and serializes each into DW/OW beats on a valid/ready stream.
// Define SOC_FIFO_RD_STREAM_MSB_FIRST_EN for MSB-first beat order; LSB-first otherwise.
module soc_fifo_rd_stream
  import soc_fifo_pkg::*;
#(
  parameter int unsigned DW = SOC_FIFO_DW,
  parameter int unsigned OW = SOC_FIFO_OW
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic          flush,
  input  logic          fifo_empty,
  output logic          fifo_pop,
  input  logic [DW-1:0] fifo_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic          m_last
);

  localparam int unsigned     RATIO    = soc_fifo_ratio(DW, OW);
  localparam int unsigned     IDXW     = soc_fifo_idx_w(RATIO);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(RATIO - 32'd1);

  `SOC_FIFO_CHECK_DIV(DW, OW)

  logic            inflight_q;
  logic            inflight_d;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] idx_d;
  logic [IDXW-1:0] sel_s;
  logic            fire_s;
  logic            release_s;
  logic            capture_s;
  logic [1:0]      cnt_s;
  logic [2:0]      credits_s;
  logic [DW-1:0]   word_s;

  soc_fifo_rd_stream_buf #(
    .DW (DW)
  ) u_buf (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .flush_i   (flush),
    .capture_i (capture_s),
    .release_i (release_s),
    .wdata_i   (fifo_dout),
    .rdata_o   (word_s),
    .cnt_o     (cnt_s)
  );

  assign m_valid   = (cnt_s != 2'd0);
  assign m_last    = (idx_q == IDX_LAST);
  assign fire_s    = m_valid & m_ready;
  assign release_s = fire_s & m_last;
  assign capture_s = inflight_q & ~flush;

  // Credits count the word retiring this cycle as free, so a full buffer can refill back-to-back.
  assign credits_s = {1'b0, cnt_s} + {2'b00, inflight_q} - {2'b00, release_s};
  assign fifo_pop  = ~flush & ~fifo_empty & (credits_s < 3'd2);
  assign inflight_d = fifo_pop;

`ifdef SOC_FIFO_RD_STREAM_MSB_FIRST_EN
  assign sel_s = IDX_LAST - idx_q;
`else
  assign sel_s = idx_q;
`endif

  assign m_data = word_s[32'(sel_s) * OW +: OW];

  // Beat index: advances per accepted beat, returns to 0 when the word retires or on flush.
  always_comb begin
    idx_d = idx_q;
    if (flush) begin
      idx_d = {IDXW{1'b0}};
    end else if (release_s) begin
      idx_d = {IDXW{1'b0}};
    end else if (fire_s) begin
      idx_d = idx_q + IDXW'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Pop tracking and beat index registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight_q <= 1'b0;
      idx_q      <= {IDXW{1'b0}};
    end else begin
      inflight_q <= inflight_d;
      idx_q      <= idx_d;
    end
  end

endmodule

// File: tb/tb_soc_fifo_rd_stream.sv
// Self-checking bench for soc_fifo_rd_stream: DW=32/OW=8 instance plus a DW=OW=32 instance.
module tb_soc_fifo_rd_stream;

  localparam int DW    = 32;
  localparam int OW    = 8;
  localparam int RATIO = DW / OW;

  logic          rclk;
  logic          rrst_n;
  logic          flush;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [DW-1:0] fifo_dout;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          m_last;

  logic          fifo_empty1;
  logic          fifo_pop1;
  logic [31:0]   fifo_dout1;
  logic          m_valid1;
  logic          m_ready1;
  logic [31:0]   m_data1;
  logic          m_last1;

  int n_cmp;
  int n_bad;

  logic [DW-1:0] q[$];
  logic [DW-1:0] popped[$];
  logic [31:0]   q1[$];

  soc_fifo_rd_stream #(.DW(DW), .OW(OW)) u_dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  soc_fifo_rd_stream #(.DW(32), .OW(32)) u_dut1 (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .flush      (1'b0),
    .fifo_empty (fifo_empty1),
    .fifo_pop   (fifo_pop1),
    .fifo_dout  (fifo_dout1),
    .m_valid    (m_valid1),
    .m_ready    (m_ready1),
    .m_data     (m_data1),
    .m_last     (m_last1)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Behavioural FIFO: registered empty flag, data valid the cycle after an accepted pop.
  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      if (fifo_pop && !fifo_empty && q.size() > 0) begin
        fifo_dout <= q[0];
        popped.push_back(q[0]);
        void'(q.pop_front());
      end
      fifo_empty <= (q.size() == 0);
    end
  end

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      fifo_empty1 <= 1'b1;
      fifo_dout1  <= '0;
    end else begin
      if (fifo_pop1 && !fifo_empty1 && q1.size() > 0) begin
        fifo_dout1 <= q1[0];
        void'(q1.pop_front());
      end
      fifo_empty1 <= (q1.size() == 0);
    end
  end

  function automatic logic [OW-1:0] beat_of(input logic [DW-1:0] w, input int k);
    int pos;
`ifdef SOC_FIFO_RD_STREAM_MSB_FIRST_EN
    pos = RATIO - 1 - k;
`else
    pos = k;
`endif
    return OW'(w >> (pos * OW));
  endfunction

  task automatic test_reset();
    rrst_n = 1'b0;
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", m_data); end
    n_cmp++; if (fifo_pop !== 1'b0) begin n_bad++; $display("FAIL reset_pop: got %b want 0", fifo_pop); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", m_last); end
    n_cmp++; if (m_last1 !== 1'b1) begin n_bad++; $display("FAIL reset_last_r1: got %b want 1", m_last1); end
    n_cmp++; if (m_valid1 !== 1'b0) begin n_bad++; $display("FAIL reset_valid_r1: got %b want 0", m_valid1); end
    rrst_n = 1'b1;
    @(negedge rclk);
  endtask

  task automatic test_basic();
    logic [DW-1:0] w;
    logic          exp_v;
    w = 32'h44332211;
    m_ready = 1'b1;
    q.push_back(w);
    for (int c = 0; c < 8; c++) begin
      @(negedge rclk); #1;
      exp_v = (c >= 2 && c <= 5);
      n_cmp++; if (m_valid !== exp_v) begin n_bad++; $display("FAIL basic_valid c%0d: got %b want %b", c, m_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (m_data !== beat_of(w, c - 2)) begin n_bad++; $display("FAIL basic_data c%0d: got %h want %h", c, m_data, beat_of(w, c - 2)); end
        n_cmp++; if (m_last !== (c == 5)) begin n_bad++; $display("FAIL basic_last c%0d: got %b want %b", c, m_last, (c == 5)); end
      end
      if (c == 0) begin
        n_cmp++; if (fifo_pop !== 1'b1) begin n_bad++; $display("FAIL basic_pop: got %b want 1", fifo_pop); end
      end
    end
    popped.delete();
  endtask

  // Stream scoreboard run: checks beats against popped words, stalls, credits and flush effects.
  task automatic run_stream(input string tag, input int ready_pct, input int flush_at,
                            input int words_in, input int max_cyc);
    int            bk;
    int            delivered;
    int            words_exp;
    logic          stall_prev;
    logic          flush_prev;
    logic [OW-1:0] d_prev;
    logic          l_prev;
    logic [OW-1:0] eb;
    bit            done;
    bk = 0; delivered = 0; words_exp = words_in;
    stall_prev = 1'b0; flush_prev = 1'b0; d_prev = '0; l_prev = 1'b0; done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge rclk);
      if (flush_prev) begin
        popped.delete();
        bk = 0;
      end
      flush   = (c == flush_at);
      m_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (stall_prev && !flush_prev) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== d_prev || m_last !== l_prev) begin
          n_bad++; $display("FAIL %s_stall c%0d: got v%b d%h l%b want v1 d%h l%b", tag, c, m_valid, m_data, m_last, d_prev, l_prev);
        end
      end
      if (flush_prev) begin
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL %s_flush_valid c%0d: got %b want 0", tag, c, m_valid); end
      end
      n_cmp++;
      if (fifo_pop !== 1'b0 && (fifo_empty || flush)) begin
        n_bad++; $display("FAIL %s_pop_gate c%0d: got pop %b (empty %b flush %b) want 0", tag, c, fifo_pop, fifo_empty, flush);
      end
      n_cmp++; if (popped.size() > 2) begin n_bad++; $display("FAIL %s_credits c%0d: got %0d want <=2", tag, c, popped.size()); end
      if (flush) begin
        words_exp = q.size();
        delivered = 0;
      end else if (m_valid === 1'b1 && m_ready) begin
        n_cmp++;
        if (popped.size() == 0) begin
          n_bad++; $display("FAIL %s_spurious c%0d: got beat %h want none", tag, c, m_data);
        end else begin
          eb = beat_of(popped[0], bk);
          if (m_data !== eb || m_last !== (bk == RATIO - 1)) begin
            n_bad++; $display("FAIL %s_beat c%0d: got d%h l%b want d%h l%b", tag, c, m_data, m_last, eb, (bk == RATIO - 1));
          end
          if (bk == RATIO - 1) begin
            void'(popped.pop_front());
            bk = 0;
            delivered++;
          end else begin
            bk++;
          end
        end
      end
      stall_prev = m_valid && !m_ready && !flush;
      d_prev     = m_data;
      l_prev     = m_last;
      flush_prev = flush;
      done       = (delivered == words_exp) && !flush;
    end
    flush = 1'b0;
    n_cmp++; if (delivered != words_exp) begin n_bad++; $display("FAIL %s_words: got %0d want %0d", tag, delivered, words_exp); end
    @(negedge rclk); #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL %s_idle: got %b want 0", tag, m_valid); end
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < 4; i++) q.push_back($urandom);
    run_stream("bp", 50, -1, 4, 400);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) q.push_back($urandom);
    run_stream("flush", 100, 6, 5, 200);
  endtask

  task automatic test_throughput();
    logic [31:0] w[16];
    logic        exp_v;
    m_ready1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w[i] = $urandom;
      q1.push_back(w[i]);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk); #1;
      exp_v = (c >= 2 && c <= 17);
      n_cmp++; if (m_valid1 !== exp_v) begin n_bad++; $display("FAIL tput_valid c%0d: got %b want %b", c, m_valid1, exp_v); end
      if (exp_v) begin
        n_cmp++; if (m_data1 !== w[c - 2] || m_last1 !== 1'b1) begin n_bad++; $display("FAIL tput_beat c%0d: got %h l%b want %h l1", c, m_data1, m_last1, w[c - 2]); end
      end
      n_cmp++; if (fifo_pop1 === 1'b1 && fifo_empty1) begin n_bad++; $display("FAIL tput_pop c%0d: got 1 want 0", c); end
    end
    m_ready1 = 1'b0;
  endtask

  task automatic test_empty_boundary();
    logic [DW-1:0] w[2];
    logic          exp_v;
    int            k;
    m_ready = 1'b1;
    w[0] = $urandom;
    w[1] = $urandom;
    q.push_back(w[0]);
    q.push_back(w[1]);
    for (int c = 0; c < 12; c++) begin
      @(negedge rclk); #1;
      exp_v = (c >= 2 && c <= 9);
      k = c - 2;
      n_cmp++; if (m_valid !== exp_v) begin n_bad++; $display("FAIL empty_valid c%0d: got %b want %b", c, m_valid, exp_v); end
      if (exp_v) begin
        n_cmp++;
        if (m_data !== beat_of(w[k / RATIO], k % RATIO) || m_last !== (k % RATIO == RATIO - 1)) begin
          n_bad++; $display("FAIL empty_beat c%0d: got %h l%b want %h l%b", c, m_data, m_last, beat_of(w[k / RATIO], k % RATIO), (k % RATIO == RATIO - 1));
        end
      end
      n_cmp++; if (fifo_empty && fifo_pop !== 1'b0) begin n_bad++; $display("FAIL empty_pop c%0d: got %b want 0", c, fifo_pop); end
    end
    popped.delete();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    w = $urandom;
    m_ready = 1'b1;
    q.push_back(w);
    repeat (5) @(negedge rclk);
    #1;
    n_cmp++; if (m_data !== beat_of(w, 2)) begin n_bad++; $display("FAIL rst_mid_pre: got %h want %h", m_data, beat_of(w, 2)); end
    rrst_n = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL rst_mid_data: got %h want 00", m_data); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rst_mid_last: got %b want 0", m_last); end
    n_cmp++; if (fifo_pop !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pop: got %b want 0", fifo_pop); end
    @(negedge rclk);
    rrst_n = 1'b1;
    popped.delete();
    q.push_back($urandom);
    run_stream("after_rst", 70, -1, 1, 100);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rrst_n   = 1'b0;
    flush    = 1'b0;
    m_ready  = 1'b0;
    m_ready1 = 1'b0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_throughput();
    test_flush();
    test_empty_boundary();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
